// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's handshake buses: instruction-memory request and
// response channels, the redirect input from execute, and the decode-side
// output queue port.
//   master : the fetch unit (drives imem_req_*, out_*)
//   slave  : the environment (imem, execute, decode)
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc, out_pc_plus4,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc, out_pc_plus4,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Issues in-order word fetches to instruction
// memory, queues the returned {pc, instr} pairs in a DEPTH-entry FIFO for
// decode, and handles branch/jump redirects by flushing the queue and
// discarding responses that belong to requests issued before the redirect.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master: imem request/response, redirect, decode output
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   stale;
  logic [CW+1:0]   credits_used;
  logic            fire;
  logic            push;
  logic            drop;
  logic            pop;

  // Every queue slot, outstanding request and pending stale response holds
  // one credit, so a response can always be pushed without a full check.
  always_comb begin
    credits_used       = {2'b00, count} + {2'b00, inflight} + {2'b00, stale};
    bus.imem_req_valid = !rst && (credits_used < (CW+2)'(DEPTH));
    bus.imem_req_addr  = fetch_pc;
    fire               = bus.imem_req_valid && bus.imem_req_ready;
    push               = bus.imem_rsp_valid && (stale == '0) && !bus.redirect_valid;
    drop               = bus.imem_rsp_valid && (stale != '0);
    bus.out_valid      = (count != '0);
    pop                = bus.out_valid && bus.out_ready;
    bus.out_pc         = pc_q[rd_ptr];
    bus.out_instr      = instr_q[rd_ptr];
    bus.out_pc_plus4   = pc_q[rd_ptr] + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      stale    <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still owed by imem (including a fire this cycle) becomes
      // stale; a response arriving this cycle is dropped and retires one.
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc   <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      stale    <= stale + inflight + CW'(fire) - CW'(bus.imem_rsp_valid);
    end else begin
      if (fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (push) begin
        rsp_pc <= rsp_pc + XLEN'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(fire) - CW'(push);
      stale    <= stale - CW'(drop);
    end
  end

  // Queue storage needs no reset; entries are only read when count != 0.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_q[wr_ptr]    <= rsp_pc;
      instr_q[wr_ptr] <= bus.imem_rsp_data;
    end
  end

  // A response with nothing outstanding means imem broke protocol.
  rsp_underflow: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> (inflight != '0 || stale != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a fixed-latency in-order memory model.
// Memory returns {16'hA5A5, addr[15:0]} for every fetched address.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int unsigned errors   = 0;
  int unsigned checks   = 0;
  int unsigned cyc      = 0;
  int unsigned fire_cnt = 0;
  int unsigned mem_lat  = 1;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;
  req_t pend[$];

  // Memory model: capture fires at the edge, answer lat cycles later.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      fire_cnt = 0;
    end else if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend.push_back('{bus.imem_req_addr, cyc + mem_lat});
      fire_cnt++;
    end
    cyc++;
  end

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
  end

  always @(negedge clk) begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = {16'hA5A5, pend[0].addr[15:0]};
      pend.pop_front();
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned lat, input logic ready, input logic oready);
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = ready;
    bus.out_ready      = oready;
    mem_lat            = lat;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_out(input string tag, input int unsigned max);
    for (int i = 0; i < int'(max) && !bus.out_valid; i++) tick();
    check(tag, bus.out_valid, 1'b1);
  endtask

  initial begin
    // 1. reset state and basic in-order flow, latency 1
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("t1_req0", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h0});
    tick();
    check("t1_req1", bus.imem_req_addr, 32'h4);
    tick();
    check("t1_req2", bus.imem_req_addr, 32'h8);
    check("t1_out0_valid", bus.out_valid, 1'b1);
    check("t1_out0_pc", bus.out_pc, 32'h0);
    check("t1_out0_instr", bus.out_instr, 32'hA5A5_0000);
    check("t1_out0_plus4", bus.out_pc_plus4, 32'h4);
    tick();
    check("t1_out1_pc", bus.out_pc, 32'h4);
    check("t1_out1_instr", bus.out_instr, 32'hA5A5_0004);
    check("t1_out1_plus4", bus.out_pc_plus4, 32'h8);

    // 2. credit limit with decode stalled
    do_reset(1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("t2_fires", fire_cnt, 4);
    check("t2_req_valid_full", bus.imem_req_valid, 1'b0);
    check("t2_addr", bus.imem_req_addr, 32'h10);
    check("t2_head_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t2_credit_back", bus.imem_req_valid, 1'b1);
    check("t2_fires_after_pop", fire_cnt, 4);
    check("t2_head_pc2", bus.out_pc, 32'h4);
    tick();
    check("t2_fire5", fire_cnt, 5);
    check("t2_req_valid_full2", bus.imem_req_valid, 1'b0);
    check("t2_addr2", bus.imem_req_addr, 32'h14);

    // 6. reset with a full queue
    tick();
    check("t6_head_stable", bus.out_pc, 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 1'b0);
    check("t6_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h0});

    // 3. request hold under back-pressure
    do_reset(1, 1'b1, 1'b1);
    tick();
    tick();
    check("t3_addr8", bus.imem_req_addr, 32'h8);
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h8});
    end
    check("t3_fires_held", fire_cnt, 2);
    bus.imem_req_ready = 1'b1;
    tick();
    check("t3_next_addr", bus.imem_req_addr, 32'hC);
    check("t3_single_fire", fire_cnt, 3);

    // 4. redirect with two responses in flight, latency 3
    do_reset(3, 1'b1, 1'b1);
    tick();
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    check("t4_redirect_addr", bus.imem_req_addr, 32'h100);
    check("t4_fires", fire_cnt, 2);
    check("t4_out_flushed", bus.out_valid, 1'b0);
    wait_out("t4_out_valid", 20);
    check("t4_first_pc", bus.out_pc, 32'h100);
    check("t4_first_instr", bus.out_instr, 32'hA5A5_0100);

    // 5. redirect coincident with a fire and a response, latency 2
    do_reset(2, 1'b1, 1'b1);
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    check("t5_redirect_addr", bus.imem_req_addr, 32'h200);
    check("t5_out_n3", bus.out_valid, 1'b0);
    tick();
    check("t5_drop1", bus.out_valid, 1'b0);
    tick();
    check("t5_drop2", bus.out_valid, 1'b0);
    tick();
    check("t5_third_valid", bus.out_valid, 1'b1);
    check("t5_third_pc", bus.out_pc, 32'h200);
    check("t5_third_plus4", bus.out_pc_plus4, 32'h204);
    tick();
    check("t5_next_pc", bus.out_pc, 32'h204);
    check("t5_next_instr", bus.out_instr, 32'hA5A5_0204);

    // 7. unaligned redirect target at top of address space; PC wraps
    do_reset(1, 1'b0, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    check("t7_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("t7_out_pc", bus.out_pc, 32'hFFFF_FFFC);
    check("t7_plus4_wrap", bus.out_pc_plus4, 32'h0);
    check("t7_instr", bus.out_instr, 32'hA5A5_FFFC);
    check("t7_addr_wrap", bus.imem_req_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
